// File: rtl/dmem_bus_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bus_bridge
//   Turns the MemoryAccess stage's RAM-side load/store strobes into one
//   valid/ready request plus one response on a variable-latency data-memory
//   bus. The pipeline is frozen with stall while a transaction is in flight.
//   read_data returns the full word; lane selection and extension are done
//   by the MEM stage.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   memory_read_enable   load request from the MEM stage
//   memory_write_enable  store request from the MEM stage
//   address              byte address from the MEM stage
//   write_data           lane-aligned store data
//   write_strobe         byte-lane enables for the store
//   read_data            registered load word returned to the MEM stage
//   stall                combinational pipeline freeze
//   bus_error            one-cycle pulse when a transaction times out
//   bus_req_valid/ready  request handshake
//   bus_addr             word-aligned request address
//   bus_write            1 = store, 0 = load
//   bus_wdata/wstrb      store data and strobes (strobes 0 for loads)
//   bus_rsp_valid        response strobe, for loads and stores
//   bus_rdata            load data, sampled with bus_rsp_valid
// ---------------------------------------------------------------------------
module dmem_bus_bridge #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned WordSize      = 4,
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned TimeoutWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 memory_read_enable,
    input  logic                 memory_write_enable,
    input  logic [AddrWidth-1:0] address,
    input  logic [DataWidth-1:0] write_data,
    input  logic [WordSize-1:0]  write_strobe,
    output logic [DataWidth-1:0] read_data,
    output logic                 stall,
    output logic                 bus_error,
    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic [AddrWidth-1:0] bus_addr,
    output logic                 bus_write,
    output logic [DataWidth-1:0] bus_wdata,
    output logic [WordSize-1:0]  bus_wstrb,
    input  logic                 bus_rsp_valid,
    input  logic [DataWidth-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t                  state;
    logic [TimeoutWidth-1:0] timeout_cnt;
    logic                    request;
    logic                    timeout_hit;

    // A store with no lanes enabled is a no-op and never reaches the bus.
    assign request     = memory_read_enable | (memory_write_enable & (|write_strobe));
    assign timeout_hit = (timeout_cnt == TimeoutWidth'(TimeoutCycles - 1));

    // Combinational so the cycle in which the request first appears is
    // already frozen; DONE releases the pipeline.
    assign stall = ((state == IDLE) & request) | (state == REQ) | (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            read_data     <= '0;
            bus_req_valid <= 1'b0;
            bus_write     <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_wstrb     <= '0;
            bus_error     <= 1'b0;
            timeout_cnt   <= '0;
        end else begin
            bus_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (request) begin
                        // Read wins when both enables are high.
                        bus_addr      <= address & ~AddrWidth'(WordSize - 1);
                        bus_write     <= ~memory_read_enable;
                        bus_wdata     <= write_data;
                        bus_wstrb     <= memory_read_enable ? '0 : write_strobe;
                        bus_req_valid <= 1'b1;
                        timeout_cnt   <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        bus_req_valid <= 1'b0;
                        bus_error     <= 1'b1;
                        if (!bus_write) read_data <= '0;
                        state         <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        if (bus_req_ready) begin
                            bus_req_valid <= 1'b0;
                            state         <= RESP;
                        end
                    end
                end
                RESP: begin
                    // A response in the final allowed cycle still completes.
                    if (bus_rsp_valid) begin
                        if (!bus_write) read_data <= bus_rdata;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        bus_error <= 1'b1;
                        if (!bus_write) read_data <= '0;
                        state     <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
